// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard scoreboard bus: decode/writeback inputs and stall controls.
interface hazard_scoreboard_if #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned LW    = 4,
  parameter int unsigned CNT_W = 32
);
  logic             id_valid;
  logic [AW-1:0]    rs1_id;
  logic [AW-1:0]    rs2_id;
  logic             rs1_used;
  logic             rs2_used;
  logic [AW-1:0]    rd_id;
  logic             rd_wr;
  logic [LW-1:0]    id_lat;
  logic             flush;
  logic             wb_valid;
  logic [AW-1:0]    wb_rd;
  logic             ifid_write;
  logic             pcwrite;
  logic             hazard;
  logic [NREG-1:0]  busy_vec;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, rs1_id, rs2_id, rs1_used, rs2_used, rd_id, rd_wr,
           id_lat, flush, wb_valid, wb_rd,
    input  ifid_write, pcwrite, hazard, busy_vec, stall_cnt
  );

  modport slave (
    input  id_valid, rs1_id, rs2_id, rs1_used, rs2_used, rd_id, rd_wr,
           id_lat, flush, wb_valid, wb_rd,
    output ifid_write, pcwrite, hazard, busy_vec, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard with latency countdowns; stalls
// RAW/WAW dependents in ID and counts stall cycles (saturating).
module hazard_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned LW    = 4,
  parameter int unsigned CNT_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  hazard_scoreboard_if.slave sb
);

  logic [LW-1:0]    cnt_q [NREG];
  logic [LW-1:0]    cnt_d [NREG];
  logic [NREG-1:0]  wbp_q;
  logic [NREG-1:0]  wbp_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [NREG-1:0]  busy;
  logic             stall;
  logic             issue;

  // Busy flags derive only from registered state, so a same-cycle writeback
  // never releases a dependent early.
  always_comb begin
    busy = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      busy[r] = (cnt_q[r] != '0) | wbp_q[r];
    end
  end

  // Stall / issue decision for the instruction in ID.
  always_comb begin
    stall = sb.id_valid & ~sb.flush &
            ((sb.rs1_used & busy[sb.rs1_id]) |
             (sb.rs2_used & busy[sb.rs2_id]) |
             (sb.rd_wr    & busy[sb.rd_id]));
    issue = sb.id_valid & ~stall & ~sb.flush & sb.rd_wr &
            (sb.rd_id != '0) & (sb.id_lat != '0);
  end

  // Scoreboard next state: issue beats writeback beats countdown.
  always_comb begin
    cnt_d[0] = '0;
    wbp_d    = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      wbp_d[r] = wbp_q[r];
      if (issue && sb.rd_id == AW'(r)) begin
        if (sb.id_lat == '1) begin
          wbp_d[r] = 1'b1;
          cnt_d[r] = '0;
        end else begin
          cnt_d[r] = sb.id_lat;
          wbp_d[r] = 1'b0;
        end
      end else if (sb.wb_valid && sb.wb_rd == AW'(r)) begin
        wbp_d[r] = 1'b0;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LW'(1);
      end
    end
  end

  // Saturating stall-cycle counter next state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset drops all pending entries asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      wbp_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      wbp_q       <= wbp_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Output drive.
  always_comb begin
    sb.ifid_write = ~stall;
    sb.pcwrite    = ~stall;
    sb.hazard     = stall;
    sb.busy_vec   = busy;
    sb.stall_cnt  = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard; a second instance with
// a 2-bit stall counter shares the same stimulus to exercise saturation.
module tb_hazard_scoreboard;

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned LW   = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   ns;

  hazard_scoreboard_if #(.NREG(NREG), .AW(AW), .LW(LW), .CNT_W(32)) sbif ();
  hazard_scoreboard_if #(.NREG(NREG), .AW(AW), .LW(LW), .CNT_W(2))  smif ();

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .LW(LW), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .sb(sbif.slave)
  );
  hazard_scoreboard #(.NREG(NREG), .AW(AW), .LW(LW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sb(smif.slave)
  );

  assign smif.id_valid = sbif.id_valid;
  assign smif.rs1_id   = sbif.rs1_id;
  assign smif.rs2_id   = sbif.rs2_id;
  assign smif.rs1_used = sbif.rs1_used;
  assign smif.rs2_used = sbif.rs2_used;
  assign smif.rd_id    = sbif.rd_id;
  assign smif.rd_wr    = sbif.rd_wr;
  assign smif.id_lat   = sbif.id_lat;
  assign smif.flush    = sbif.flush;
  assign smif.wb_valid = sbif.wb_valid;
  assign smif.wb_rd    = sbif.wb_rd;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_in();
    sbif.id_valid = 1'b0; sbif.rs1_id = '0; sbif.rs2_id = '0;
    sbif.rs1_used = 1'b0; sbif.rs2_used = 1'b0; sbif.rd_id = '0;
    sbif.rd_wr = 1'b0; sbif.id_lat = '0; sbif.flush = 1'b0;
    sbif.wb_valid = 1'b0; sbif.wb_rd = '0;
  endtask

  task automatic drive_id(input logic [AW-1:0] rs1, input logic u1,
                          input logic [AW-1:0] rs2, input logic u2,
                          input logic [AW-1:0] rd, input logic wr,
                          input logic [LW-1:0] lat);
    sbif.id_valid = 1'b1; sbif.rs1_id = rs1; sbif.rs1_used = u1;
    sbif.rs2_id = rs2; sbif.rs2_used = u2; sbif.rd_id = rd;
    sbif.rd_wr = wr; sbif.id_lat = lat; sbif.flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts stall cycles with the current ID inputs held; returns at the
  // negedge of the first non-stalled cycle (or after the limit).
  task automatic count_stalls(output int n, input int limit);
    n = 0;
    @(negedge clk);
    while (sbif.hazard === 1'b1 && n < limit) begin
      n++;
      step();
      @(negedge clk);
    end
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    #3;
    chk("rst_ifid",  64'(sbif.ifid_write), 64'd1);
    chk("rst_pcw",   64'(sbif.pcwrite),    64'd1);
    chk("rst_haz",   64'(sbif.hazard),     64'd0);
    chk("rst_busy",  64'(sbif.busy_vec),   64'd0);
    chk("rst_scnt",  64'(sbif.stall_cnt),  64'd0);
    step();
    rst_n = 1'b1;

    // Load-use: lat=1 gives exactly one bubble.
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 4'd1);
    @(negedge clk);
    chk("lu_prod_haz", 64'(sbif.hazard), 64'd0);
    step();
    drive_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 4'd0);
    @(negedge clk);
    chk("lu_haz",   64'(sbif.hazard),     64'd1);
    chk("lu_pcw",   64'(sbif.pcwrite),    64'd0);
    chk("lu_ifid",  64'(sbif.ifid_write), 64'd0);
    chk("lu_busy5", 64'(sbif.busy_vec[5]), 64'd1);
    step();
    @(negedge clk);
    chk("lu_issue", 64'(sbif.hazard),    64'd0);
    chk("lu_scnt",  64'(sbif.stall_cnt), 64'd1);
    chk("lu_sat1",  64'(smif.stall_cnt), 64'd1);
    step();

    // Multicycle producer lat=3 on rs2.
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 4'd3);
    step();
    drive_id(5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 4'd0);
    count_stalls(ns, 20);
    chk("mul_stalls", 64'(ns), 64'd3);
    chk("mul_busy7",  64'(sbif.busy_vec[7]), 64'd0);
    chk("mul_scnt",   64'(sbif.stall_cnt), 64'd4);
    step();

    // Variable-latency divider: released only by writeback.
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 4'hF);
    step();
    drive_id(5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 4'd0);
    ns = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (sbif.hazard === 1'b1) ns++;
      step();
    end
    chk("div_stall9", 64'(ns), 64'd9);
    sbif.wb_valid = 1'b1; sbif.wb_rd = 5'd9;
    @(negedge clk);
    chk("div_wb_haz", 64'(sbif.hazard), 64'd1);
    step();
    sbif.wb_valid = 1'b0;
    @(negedge clk);
    chk("div_busy9", 64'(sbif.busy_vec[9]), 64'd0);
    chk("div_issue", 64'(sbif.hazard), 64'd0);
    chk("div_scnt",  64'(sbif.stall_cnt), 64'd14);
    step();

    // WAW: non-reading write to a pending destination.
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 4'd2);
    step();
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 4'd1);
    count_stalls(ns, 20);
    chk("waw_stalls", 64'(ns), 64'd2);
    step();
    idle_in();
    step();

    // x0 is never tracked.
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'd5);
    step();
    drive_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 4'd0);
    @(negedge clk);
    chk("x0_haz",  64'(sbif.hazard),   64'd0);
    chk("x0_busy", 64'(sbif.busy_vec), 64'd0);
    step();

    // Flush: dependent killed, no stall, no entry.
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 4'd2);
    step();
    drive_id(5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 4'd3);
    sbif.flush = 1'b1;
    @(negedge clk);
    chk("fl_haz", 64'(sbif.hazard), 64'd0);
    step();
    idle_in();
    @(negedge clk);
    chk("fl_busy11", 64'(sbif.busy_vec[11]), 64'd0);
    chk("fl_busy10", 64'(sbif.busy_vec[10]), 64'd1);
    chk("fl_scnt",   64'(sbif.stall_cnt), 64'd16);
    step();

    // Issue and writeback to the same register: the new entry wins;
    // a writeback to a non-pending register is ignored.
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 4'hF);
    sbif.wb_valid = 1'b1; sbif.wb_rd = 5'd4;
    step();
    idle_in();
    sbif.wb_valid = 1'b1; sbif.wb_rd = 5'd12;
    @(negedge clk);
    chk("col_busy4", 64'(sbif.busy_vec[4]), 64'd1);
    step();
    idle_in();
    @(negedge clk);
    chk("wb_other", 64'(sbif.busy_vec), 64'h10);
    chk("sat_cnt",  64'(smif.stall_cnt), 64'd3);

    // Asynchronous reset mid-stall.
    step();
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 4'hF);
    step();
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, 4'd9);
    step();
    drive_id(5'd20, 1'b1, 5'd21, 1'b1, 5'd22, 1'b1, 4'd0);
    @(negedge clk);
    chk("ar_haz_pre", 64'(sbif.hazard), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_busy", 64'(sbif.busy_vec),  64'd0);
    chk("ar_scnt", 64'(sbif.stall_cnt), 64'd0);
    chk("ar_pcw",  64'(sbif.pcwrite),   64'd1);
    chk("ar_haz",  64'(sbif.hazard),    64'd0);
    chk("ar_sat",  64'(smif.stall_cnt), 64'd0);
    idle_in();
    step();
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
